// File: rtl/lanectrl_pause_arbiter.sv
// rtl/lanectrl_pause_arbiter.sv - round-robin HS_IO clock-pause arbiter for lane-control clients
// Sequences each pause as setup, grant window, hold and release gap around a one-hot grant.
module lanectrl_pause_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int PRE_CYCLES     = 2,
  parameter int POST_CYCLES    = 2,
  parameter int GAP_CYCLES     = 3,
  parameter int MAX_GNT_CYCLES = 64
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_REQ-1:0] REQ,
  output logic [NUM_REQ-1:0] GNT,
  output logic               HS_IO_CLK_PAUSE,
  output logic               BUSY,
  output logic               TIMEOUT
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [7:0] PRE_LD  = 8'(PRE_CYCLES - 1);
  localparam logic [7:0] POST_LD = 8'(POST_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] GNT_LD  = 8'(MAX_GNT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GRANT,
    HOLD,
    GAP
  } state_t;

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      win_idx;
  logic [IW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] winner_oh;
  logic               found;
  logic [7:0]         cnt;
  int                 idx;

  // First eligible requester at or after ptr, wrapping around.
  always_comb begin
    eligible = REQ & ~mask;
    found    = 1'b0;
    win_idx  = ptr;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && eligible[idx]) begin
        found   = 1'b1;
        win_idx = IW'(idx);
      end
    end
    ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);
  end

  assign winner_oh = NUM_REQ'(1) << winner;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state           <= IDLE;
      ptr             <= '0;
      winner          <= '0;
      mask            <= '0;
      cnt             <= '0;
      GNT             <= '0;
      HS_IO_CLK_PAUSE <= 1'b0;
      BUSY            <= 1'b0;
      TIMEOUT         <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      mask    <= mask & REQ;
      case (state)
        IDLE: begin
          if (found) begin
            state           <= SETUP;
            winner          <= win_idx;
            ptr             <= ptr_next;
            cnt             <= PRE_LD;
            HS_IO_CLK_PAUSE <= 1'b1;
            BUSY            <= 1'b1;
          end
        end
        SETUP: begin
          // An abandoned request still gets the full hold so the synchroniser sees a clean pause.
          if (!REQ[winner]) begin
            state <= HOLD;
            cnt   <= POST_LD;
          end else if (cnt == 8'd0) begin
            state <= GRANT;
            cnt   <= GNT_LD;
            GNT   <= winner_oh;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GRANT: begin
          if (!REQ[winner]) begin
            state <= HOLD;
            cnt   <= POST_LD;
            GNT   <= '0;
          end else if (cnt == 8'd0) begin
            state   <= HOLD;
            cnt     <= POST_LD;
            GNT     <= '0;
            TIMEOUT <= 1'b1;
            mask    <= (mask & REQ) | winner_oh;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) begin
            state           <= GAP;
            cnt             <= GAP_LD;
            HS_IO_CLK_PAUSE <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state           <= IDLE;
          GNT             <= '0;
          HS_IO_CLK_PAUSE <= 1'b0;
          BUSY            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lanectrl_pause_arbiter.sv
// tb/tb_lanectrl_pause_arbiter.sv - self-checking bench for lanectrl_pause_arbiter
// Timeline reference model predicts each pause sequence from its start and release cycles.
module tb_lanectrl_pause_arbiter;

  localparam int N    = 4;
  localparam int PRE  = 2;
  localparam int POST = 2;
  localparam int GAP  = 3;
  localparam int MAXG = 8;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] GNT;
  logic         HS_IO_CLK_PAUSE;
  logic         BUSY;
  logic         TIMEOUT;

  lanectrl_pause_arbiter #(
    .NUM_REQ(N), .PRE_CYCLES(PRE), .POST_CYCLES(POST),
    .GAP_CYCLES(GAP), .MAX_GNT_CYCLES(MAXG)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT),
    .HS_IO_CLK_PAUSE(HS_IO_CLK_PAUSE), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int total  = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Model: a sequence is described by the cycle PAUSE rose (tp) and the cycle GNT
  // ended or the request was abandoned (off); every output follows from those.
  int           c;
  int           act;
  int           w_m;
  int           tp;
  int           off;
  int           tto;
  int           ptr_m;
  logic [N-1:0] mask_m;

  task automatic model_reset();
    act = 0; w_m = 0; tp = 0; off = -1; tto = -1; ptr_m = 0; mask_m = '0;
  endtask

  task automatic step(input logic [N-1:0] r);
    logic [N-1:0] el;
    logic [N-1:0] setm;
    logic [N-1:0] eg;
    logic         ep;
    logic         eb;
    int           n;
    REQ  = r;
    setm = '0;
    if (act == 0 || (off >= 0 && c >= off + POST + GAP)) begin
      act = 0;
      el  = r & ~mask_m;
      if (el != '0) begin
        for (int k = N - 1; k >= 0; k--)
          if (el[(ptr_m + k) % N]) w_m = (ptr_m + k) % N;
        ptr_m = (w_m + 1) % N;
        act   = 1;
        tp    = c + 1;
        off   = -1;
      end
    end else if (off < 0) begin
      if (!r[w_m]) off = c + 1;
      else if (c == tp + PRE + MAXG - 1) begin
        off = c + 1;
        tto = c + 1;
        setm[w_m] = 1'b1;
      end
    end
    mask_m = (mask_m & r) | setm;
    c++;
    n  = c;
    ep = (act != 0) && n >= tp && (off < 0 || n < off + POST);
    eg = ((act != 0) && n >= tp + PRE && (off < 0 || n < off)) ? N'(1) << w_m : '0;
    eb = (act != 0) && (off < 0 || n < off + POST + GAP);
    @(posedge CLK);
    #1;
    chk("gnt", 32'(GNT), 32'(eg));
    chk("pause", 32'(HS_IO_CLK_PAUSE), 32'(ep));
    chk("busy", 32'(BUSY), 32'(eb));
    chk("timeout", 32'(TIMEOUT), 32'(n == tto));
  endtask

  // Continuous invariants; a reset legitimately shortens a low interval.
  int lowcnt = 0;
  bit armed  = 1'b0;
  always @(negedge CLK) begin
    if (RESET) begin
      armed  = 1'b0;
      lowcnt = 0;
    end else begin
      chk("onehot0", 32'($onehot0(GNT)), 32'd1);
      chk("gnt_needs_pause", 32'((GNT == '0) || HS_IO_CLK_PAUSE), 32'd1);
      if (HS_IO_CLK_PAUSE) begin
        if (armed && lowcnt > 0) chk("gap_len", 32'(lowcnt >= GAP), 32'd1);
        armed  = 1'b1;
        lowcnt = 0;
      end else begin
        lowcnt++;
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] prevg;
    int           hc[N];
    int           order[$];
    int           exp_ord[5];
    int           n;
    int           g2;
    int           to_cnt;
    int           first_other;
    int           pc;
    int           gc;
    int           seen;
    exp_ord = '{0, 1, 2, 3, 0};
    c = 0;
    model_reset();

    #1 RESET = 1'b1;
    #1;
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_timeout", 32'(TIMEOUT), 32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1'b0;

    // T1: single request with fixed, hand-derived timing
    for (int k = 0; k <= 16; k++) begin
      step((k < 10) ? 4'b0010 : 4'b0000);
      n = k + 1;
      chk("t1_pause", 32'(HS_IO_CLK_PAUSE), 32'(n >= 1 && n <= 12));
      chk("t1_gnt", 32'(GNT), (n >= 3 && n <= 10) ? 32'h2 : 32'h0);
      chk("t1_busy", 32'(BUSY), 32'(n >= 1 && n <= 15));
    end

    // T4: one-cycle pulse abandons the sequence in SETUP
    step(4'b0000);
    step(4'b1000);
    pc = HS_IO_CLK_PAUSE ? 1 : 0;
    gc = (GNT != '0) ? 1 : 0;
    for (int k = 0; k < 12; k++) begin
      step(4'b0000);
      if (HS_IO_CLK_PAUSE) pc++;
      if (GNT != '0) gc++;
    end
    chk("t4_pause_cycles", 32'(pc), 32'(1 + POST));
    chk("t4_gnt_cycles", 32'(gc), 32'd0);
    chk("t4_idle", 32'(BUSY), 32'd0);

    // T2: all clients requesting, each releasing 4 cycles into its grant
    r = 4'hf;
    prevg = '0;
    for (int i = 0; i < N; i++) hc[i] = 0;
    for (int k = 0; k < 200 && order.size() < 5; k++) begin
      step(r);
      if (GNT != '0 && prevg == '0) order.push_back($clog2(GNT));
      prevg = GNT;
      for (int i = 0; i < N; i++) begin
        if (!r[i]) r[i] = 1'b1;
        else if (GNT[i]) begin
          hc[i]++;
          if (hc[i] == 4) begin
            r[i]  = 1'b0;
            hc[i] = 0;
          end
        end
      end
    end
    chk("t2_grant_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk("t2_grant_order", 32'(order[i]), 32'(exp_ord[i]));
    for (int k = 0; k < 15; k++) step(4'b0000);

    // T3: grant timeout, masking and re-arm after REQ toggles
    r = 4'b0100;
    g2 = 0; to_cnt = 0; first_other = -1;
    for (int k = 0; k < 80 && first_other < 0; k++) begin
      step(r);
      if (GNT[2]) g2++;
      if (TIMEOUT) to_cnt++;
      if (GNT != '0 && !GNT[2]) first_other = $clog2(GNT);
      if (g2 == 2) r = 4'b0101;
    end
    chk("t3_gnt2_cycles", 32'(g2), 32'(MAXG));
    chk("t3_timeout_pulses", 32'(to_cnt), 32'd1);
    chk("t3_next_winner", 32'(first_other), 32'd0);
    g2 = 0;
    for (int k = 0; k < 25; k++) begin
      step(4'b0100);
      if (GNT[2]) g2++;
    end
    chk("t3_masked_gnt2", 32'(g2), 32'd0);
    step(4'b0000);
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      step(4'b0100);
      if (GNT[2]) seen = 1;
    end
    chk("t3_regrant", 32'(seen), 32'd1);
    for (int k = 0; k < 20; k++) step(4'b0000);

    // T5: asynchronous reset during GRANT
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      step(4'b0010);
      if (GNT[1]) seen = 1;
    end
    chk("t5_granted", 32'(seen), 32'd1);
    step(4'b0010);
    #2 RESET = 1'b1;
    #1;
    chk("t5_gnt", 32'(GNT), 32'd0);
    chk("t5_pause", 32'(HS_IO_CLK_PAUSE), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    model_reset();
    first_other = -1;
    for (int k = 0; k < 20 && first_other < 0; k++) begin
      step(4'b1111);
      if (GNT != '0) first_other = $clog2(GNT);
    end
    chk("t5_ptr_zero", 32'(first_other), 32'd0);
    for (int k = 0; k < 20; k++) step(4'b0000);

    // T6: random request traffic against the model and the invariants
    r = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (r[i]) begin
          if ($urandom_range(7) == 0) r[i] = 1'b0;
        end else if ($urandom_range(3) == 0) r[i] = 1'b1;
      end
      step(r);
    end
    for (int k = 0; k < 20; k++) step(4'b0000);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
